// File: rtl/aes_key_expansion_seq_if.sv
// +--------------------------------------------------------------------------+
// | aes_key_expansion_seq_if : key-offer and round-key read bus, rev 1.0     |
// | rd_inv_key exists only when AES_KEYEXP_INV_KEY_EN is defined             |
// +--------------------------------------------------------------------------+
`default_nettype none

interface aes_key_expansion_seq_if #(
  parameter int NK = 4,
  parameter int NR = NK + 6
);
  localparam int RW = $clog2(NR + 1);

  logic                 key_valid;
  logic                 key_ready;
  logic [32*NK-1:0]     key;
  logic                 busy;
  logic                 done;
  logic                 rd_en;
  logic [RW-1:0]        rd_round;
  logic                 rd_vld;
  logic [127:0]         rd_key;
`ifdef AES_KEYEXP_INV_KEY_EN
  logic [127:0]         rd_inv_key;

  modport master (
    output key_valid, key, rd_en, rd_round,
    input  key_ready, busy, done, rd_vld, rd_key, rd_inv_key
  );
  modport slave (
    input  key_valid, key, rd_en, rd_round,
    output key_ready, busy, done, rd_vld, rd_key, rd_inv_key
  );
`else
  modport master (
    output key_valid, key, rd_en, rd_round,
    input  key_ready, busy, done, rd_vld, rd_key
  );
  modport slave (
    input  key_valid, key, rd_en, rd_round,
    output key_ready, busy, done, rd_vld, rd_key
  );
`endif
endinterface

`default_nettype wire

// File: rtl/aes_key_expansion_seq.sv
// +--------------------------------------------------------------------------+
// | aes_key_expansion_seq : one-word-per-cycle AES key schedule, rev 1.0     |
// | AES_KEYEXP_INV_KEY_EN adds the equivalent-inverse-cipher read key        |
// +--------------------------------------------------------------------------+
`default_nettype none

module aes_key_expansion_seq #(
  parameter int NK = 4,
  parameter int NR = NK + 6
) (
  input  logic                      clk,
  input  logic                      rst_n,
  aes_key_expansion_seq_if.slave    bus
);
  localparam int NW = 4 * (NR + 1);
  localparam int AW = $clog2(NW);
  localparam int CW = $clog2(NW + 1);
  localparam int RW = $clog2(NR + 1);

  generate
    if (!(NK == 4 || NK == 6 || NK == 8)) begin : g_bad_nk
      $error("aes_key_expansion_seq: NK must be 4, 6 or 8");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_EXPAND, S_DONE} state_t;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] b;
    sq = x;
    b  = 8'h01;
    for (int k = 0; k < 7; k++) begin
      sq = gf_mul(sq, sq);
      b  = gf_mul(b, sq);
    end
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  state_t         r_state;
  logic           r_key_ready;
  logic           r_busy;
  logic           r_done;
  logic [CW-1:0]  r_cnt;
  logic [2:0]     r_mod;
  logic [7:0]     r_rcon;
  logic [31:0]    r_w [NW];
  logic           r_rd_vld;
  logic [127:0]   r_rd_key;

  logic           w_accept;
  logic [31:0]    w_temp;
  logic [31:0]    w_prev_nk;
  logic [31:0]    w_sub_in;
  logic [31:0]    w_sub;
  logic [31:0]    w_new;

  assign w_accept  = bus.key_valid && r_key_ready;
  assign w_temp    = r_w[AW'(r_cnt - CW'(1))];
  assign w_prev_nk = r_w[AW'(r_cnt - CW'(NK))];
  assign w_sub_in  = (r_mod == 3'd0) ? {w_temp[23:0], w_temp[31:24]} : w_temp;
  assign w_sub     = {sbox(w_sub_in[31:24]), sbox(w_sub_in[23:16]),
                      sbox(w_sub_in[15:8]),  sbox(w_sub_in[7:0])};

  always_comb begin
    w_new = w_prev_nk ^ w_temp;
    if (r_mod == 3'd0)
      w_new = w_prev_nk ^ w_sub ^ {r_rcon, 24'h000000};
    else if (NK > 6 && r_mod == 3'd4)
      w_new = w_prev_nk ^ w_sub;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_key_ready <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_cnt       <= '0;
      r_mod       <= 3'd0;
      r_rcon      <= 8'h01;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (bus.key_valid) begin
            r_state     <= S_EXPAND;
            r_key_ready <= 1'b0;
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
            r_cnt       <= CW'(NK);
            r_mod       <= 3'd0;
            r_rcon      <= 8'h01;
          end
        end
        S_EXPAND: begin
          r_cnt <= r_cnt + CW'(1);
          r_mod <= (r_mod == 3'(NK - 1)) ? 3'd0 : r_mod + 3'd1;
          if (r_mod == 3'd0)
            r_rcon <= {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1b : 8'h00);
          if (r_cnt == CW'(NW - 1)) begin
            r_state     <= S_DONE;
            r_key_ready <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Word store has no reset: availability is governed solely by r_cnt.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      for (int k = 0; k < NK; k++)
        r_w[AW'(k)] <= bus.key[32*k +: 32];
    end else if (r_state == S_EXPAND) begin
      r_w[AW'(r_cnt)] <= w_new;
    end
  end

  logic [AW-1:0]  w_rd_base;
  logic [7:0]     w_need;
  logic           w_avail;
  logic [127:0]   w_rd_key;

  assign w_rd_base = AW'({bus.rd_round, 2'b00});
  assign w_need    = 8'({bus.rd_round, 2'b00}) + 8'd4;
  assign w_avail   = bus.rd_en && (bus.rd_round <= RW'(NR)) && (8'(r_cnt) >= w_need);

  generate
    for (genvar j = 0; j < 4; j++) begin : g_rd_word
      assign w_rd_key[32*j +: 32] = r_w[w_rd_base + AW'(j)];
    end
  endgenerate

`ifdef AES_KEYEXP_INV_KEY_EN
  function automatic logic [31:0] inv_mix(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
            gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
            gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
            gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
  endfunction

  logic [127:0] r_rd_inv_key;
  logic [127:0] w_rd_inv_key;
  logic         w_inner;

  assign w_inner = (bus.rd_round != '0) && (bus.rd_round != RW'(NR));
  assign w_rd_inv_key = w_inner ? {inv_mix(w_rd_key[127:96]), inv_mix(w_rd_key[95:64]),
                                   inv_mix(w_rd_key[63:32]),  inv_mix(w_rd_key[31:0])}
                                : w_rd_key;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_rd_inv_key <= '0;
    else if (w_avail)
      r_rd_inv_key <= w_rd_inv_key;
  end

  assign bus.rd_inv_key = r_rd_inv_key;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_vld <= 1'b0;
      r_rd_key <= '0;
    end else begin
      r_rd_vld <= w_avail;
      if (w_avail)
        r_rd_key <= w_rd_key;
    end
  end

  assign bus.key_ready = r_key_ready;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.rd_vld    = r_rd_vld;
  assign bus.rd_key    = r_rd_key;

endmodule

`default_nettype wire

// File: tb/tb_aes_key_expansion_seq.sv
// +--------------------------------------------------------------------------+
// | tb_aes_key_expansion_seq : directed FIPS-197 vectors for Nk=4/6/8, 1.0  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_aes_key_expansion_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   tcyc = 0;
  int   acc;

  always #5 clk = ~clk;

  aes_key_expansion_seq_if #(.NK(4)) if4 ();
  aes_key_expansion_seq_if #(.NK(6)) if6 ();
  aes_key_expansion_seq_if #(.NK(8)) if8 ();

  aes_key_expansion_seq #(.NK(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(if4.slave));
  aes_key_expansion_seq #(.NK(6)) u_dut6 (.clk(clk), .rst_n(rst_n), .bus(if6.slave));
  aes_key_expansion_seq #(.NK(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(if8.slave));

  localparam logic [127:0] KEY4 = {32'h09cf4f3c, 32'habf71588, 32'h28aed2a6, 32'h2b7e1516};
  localparam logic [191:0] KEY6 = {32'h522c6b7b, 32'h62f8ead2, 32'h809079e5, 32'hc810f32b,
                                   32'hda0e6452, 32'h8e73b0f7};
  localparam logic [255:0] KEY8 = {32'h0914dff4, 32'h2d9810a3, 32'h3b6108d7, 32'h1f352c07,
                                   32'h857d7781, 32'h2b73aef0, 32'h15ca71be, 32'h603deb10};
  localparam logic [127:0] RK1  = {32'h2a6c7605, 32'h23a33939, 32'h88542cb1, 32'ha0fafe17};
  localparam logic [127:0] RK2  = {32'h7359f67f, 32'h5935807a, 32'h7a96b943, 32'hf2c295f2};
  localparam logic [127:0] RK10 = {32'hb6630ca6, 32'he13f0cc8, 32'hc9ee2589, 32'hd014f9a8};

  task automatic step();
    @(posedge clk);
    #1;
    tcyc++;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

`ifdef AES_KEYEXP_INV_KEY_EN
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] imc_model(input logic [31:0] c);
    logic [7:0] a [4];
    logic [7:0] m9 [4], mb [4], md [4], me [4];
    for (int i = 0; i < 4; i++) begin
      logic [7:0] x2, x4, x8;
      a[i]  = c[31 - 8*i -: 8];
      x2    = xt(a[i]);
      x4    = xt(x2);
      x8    = xt(x4);
      m9[i] = x8 ^ a[i];
      mb[i] = x8 ^ x2 ^ a[i];
      md[i] = x8 ^ x4 ^ a[i];
      me[i] = x8 ^ x4 ^ x2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction
`endif

  initial begin
    if4.key_valid = 1'b0; if4.key = '0; if4.rd_en = 1'b0; if4.rd_round = '0;
    if6.key_valid = 1'b0; if6.key = '0; if6.rd_en = 1'b0; if6.rd_round = '0;
    if8.key_valid = 1'b0; if8.key = '0; if8.rd_en = 1'b0; if8.rd_round = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_key_ready", 128'(if4.key_ready), 128'd1);
    chk("rst_busy",      128'(if4.busy),      128'd0);
    chk("rst_done",      128'(if4.done),      128'd0);
    chk("rst_rd_vld",    128'(if4.rd_vld),    128'd0);
    chk("rst_rd_key",    if4.rd_key,          128'd0);
    rst_n = 1'b1;
    step();

    // Nothing is readable before a key has been accepted.
    if4.rd_en = 1'b1; if4.rd_round = 4'd0;
    step();
    chk("idle_read_vld", 128'(if4.rd_vld), 128'd0);
    if4.rd_en = 1'b0;

    if4.key = KEY4; if4.key_valid = 1'b1;
    if6.key = KEY6; if6.key_valid = 1'b1;
    if8.key = KEY8; if8.key_valid = 1'b1;
    step();
    acc = tcyc;
    if4.key_valid = 1'b0; if6.key_valid = 1'b0; if8.key_valid = 1'b0;
    chk("exp_key_ready", 128'(if4.key_ready), 128'd0);
    chk("exp_busy",      128'(if4.busy),      128'd1);

    if4.rd_en = 1'b1; if4.rd_round = 4'd1;
    step();
    chk("r1_early_vld", 128'(if4.rd_vld), 128'd0);
    while (!if4.rd_vld && (tcyc - acc) < 30) step();
    chk("r1_first_vld_cycle", 128'(tcyc - acc), 128'd5);
    chk("r1_key", if4.rd_key, RK1);

    // Offer a different key mid-expansion; it must not be captured.
    if4.rd_en = 1'b0;
    if4.key = ~KEY4; if4.key_valid = 1'b1;
    step();
    chk("kv_in_expand_ready", 128'(if4.key_ready), 128'd0);
    step();
    if4.key_valid = 1'b0; if4.key = KEY4;

    if4.rd_en = 1'b1; if4.rd_round = 4'd0;
    step();
    chk("r0_vld", 128'(if4.rd_vld), 128'd1);
    chk("r0_key", if4.rd_key, KEY4);
    if4.rd_round = 4'd11;
    step();
    chk("oor_vld",  128'(if4.rd_vld), 128'd0);
    chk("oor_hold", if4.rd_key, KEY4);
    if4.rd_en = 1'b0;

    while (!if4.done && (tcyc - acc) < 100) step();
    chk("nk4_latency", 128'(tcyc - acc), 128'd40);
    chk("nk4_busy_done", 128'(if4.busy), 128'd0);
    chk("nk4_ready_done", 128'(if4.key_ready), 128'd1);
    while (!if6.done && (tcyc - acc) < 100) step();
    chk("nk6_latency", 128'(tcyc - acc), 128'd46);
    while (!if8.done && (tcyc - acc) < 100) step();
    chk("nk8_latency", 128'(tcyc - acc), 128'd52);

    if4.rd_en = 1'b1; if4.rd_round = 4'd10;
    if6.rd_en = 1'b1; if6.rd_round = 4'd12;
    if8.rd_en = 1'b1; if8.rd_round = 4'd14;
    step();
    chk("nk4_r10_vld", 128'(if4.rd_vld), 128'd1);
    chk("nk4_r10_key", if4.rd_key, RK10);
    chk("nk6_r12_vld", 128'(if6.rd_vld), 128'd1);
    chk("nk6_w51",     128'(if6.rd_key[127:96]), 128'h01002202);
    chk("nk8_r14_vld", 128'(if8.rd_vld), 128'd1);
    chk("nk8_w59",     128'(if8.rd_key[127:96]), 128'h706c631e);
    if6.rd_en = 1'b0; if8.rd_en = 1'b0;
`ifdef AES_KEYEXP_INV_KEY_EN
    chk("inv_r10_eq", if4.rd_inv_key, RK10);
`endif
    if4.rd_round = 4'd2;
    step();
    chk("nk4_r2_key", if4.rd_key, RK2);
`ifdef AES_KEYEXP_INV_KEY_EN
    chk("inv_r2", if4.rd_inv_key, {imc_model(RK2[127:96]), imc_model(RK2[95:64]),
                                   imc_model(RK2[63:32]),  imc_model(RK2[31:0])});
    if4.rd_round = 4'd0;
    step();
    chk("inv_r0_eq", if4.rd_inv_key, KEY4);
    if4.rd_round = 4'd1;
    step();
    chk("inv_r1", if4.rd_inv_key, {imc_model(RK1[127:96]), imc_model(RK1[95:64]),
                                   imc_model(RK1[63:32]),  imc_model(RK1[31:0])});
`endif

    // Re-key from DONE: old rounds beyond the key words vanish.
    if4.rd_en = 1'b0;
    if4.key_valid = 1'b1;
    step();
    acc = tcyc;
    if4.key_valid = 1'b0;
    chk("rekey_done_clr", 128'(if4.done), 128'd0);
    if4.rd_en = 1'b1; if4.rd_round = 4'd10;
    step();
    chk("rekey_stale_vld", 128'(if4.rd_vld), 128'd0);
    if4.rd_round = 4'd0;
    step();
    chk("rekey_r0_vld", 128'(if4.rd_vld), 128'd1);

    while ((tcyc - acc) < 20) step();
    rst_n = 1'b0;
    #1;
    chk("midrst_done",   128'(if4.done),      128'd0);
    chk("midrst_ready",  128'(if4.key_ready), 128'd1);
    chk("midrst_busy",   128'(if4.busy),      128'd0);
    chk("midrst_rd_vld", 128'(if4.rd_vld),    128'd0);
    if4.rd_en = 1'b0;
    step();
    rst_n = 1'b1;
    step();

    if4.key_valid = 1'b1;
    step();
    acc = tcyc;
    if4.key_valid = 1'b0;
    while (!if4.done && (tcyc - acc) < 100) step();
    chk("fresh_latency", 128'(tcyc - acc), 128'd40);
    if4.rd_en = 1'b1; if4.rd_round = 4'd10;
    step();
    chk("fresh_r10_key", if4.rd_key, RK10);
    if4.rd_round = 4'd1;
    step();
    chk("fresh_r1_key", if4.rd_key, RK1);
    if4.rd_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

`default_nettype wire
